// File: rtl/scan_mux.sv
// Registered N-channel multiplexer with a manual select and an auto-scanning
// sequencer; drives a valid strobe and an end-of-frame pulse alongside the data.
module scan_mux #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int HOLD     = 1,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] i,
    input  logic [SEL_W-1:0]          s,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          o,
    output logic                      o_valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      frame_done
);

    localparam int NSLOT = 1 << SEL_W;
    localparam int HC_W  = $clog2(HOLD + 1);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CH_CNT   = (SEL_W + 1)'(CHANNELS);
    localparam logic [HC_W-1:0]  HOLD_L   = HC_W'(HOLD);

    typedef enum logic [0:0] {IDLE, SCAN} state_t;

    state_t            state_reg, state_next;
    logic [SEL_W-1:0]  ptr_reg, ptr_next;
    logic [HC_W-1:0]   hold_reg, hold_next;
    logic [WIDTH-1:0]  o_reg, o_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic              valid_reg, valid_next;
    logic              fd_reg, fd_next;

    // Channel table padded to a power of two so any select value indexes safely.
    logic [WIDTH-1:0] chan [NSLOT];

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_chan
            if (gi < CHANNELS) begin : g_live
                assign chan[gi] = i[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign chan[gi] = '0;
            end
        end
    endgenerate

    logic             s_in_range;
    logic [SEL_W-1:0] ptr_adv;

    assign s_in_range = ({1'b0, s} < CH_CNT);
    assign ptr_adv    = (ptr_reg == LAST_SEL) ? '0 : ptr_reg + SEL_W'(1);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        hold_next  = hold_reg;
        o_next     = o_reg;
        sel_next   = sel_reg;
        valid_next = 1'b0;
        fd_next    = 1'b0;

        if (!mode) begin
            state_next = IDLE;
            ptr_next   = '0;
            hold_next  = '0;
            if (en) begin
                sel_next   = s;
                o_next     = s_in_range ? chan[s] : '0;
                valid_next = s_in_range;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        state_next = SCAN;
                        ptr_next   = '0;
                        hold_next  = HC_W'(1);
                        o_next     = chan[0];
                        sel_next   = '0;
                        valid_next = 1'b1;
                    end
                end
                SCAN: begin
                    if (!en) begin
                        // Dropping enable discards the scan position.
                        state_next = IDLE;
                        ptr_next   = '0;
                        hold_next  = '0;
                    end else if (hold_reg < HOLD_L) begin
                        hold_next  = hold_reg + HC_W'(1);
                        o_next     = chan[ptr_reg];
                        sel_next   = ptr_reg;
                        valid_next = 1'b1;
                    end else begin
                        ptr_next   = ptr_adv;
                        hold_next  = HC_W'(1);
                        o_next     = chan[ptr_adv];
                        sel_next   = ptr_adv;
                        valid_next = 1'b1;
                        fd_next    = (ptr_reg == LAST_SEL);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            hold_reg  <= '0;
            o_reg     <= '0;
            sel_reg   <= '0;
            valid_reg <= 1'b0;
            fd_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            hold_reg  <= hold_next;
            o_reg     <= o_next;
            sel_reg   <= sel_next;
            valid_reg <= valid_next;
            fd_reg    <= fd_next;
        end
    end

    assign o          = o_reg;
    assign o_valid    = valid_reg;
    assign cur_sel    = sel_reg;
    assign frame_done = fd_reg;

endmodule
